// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle control unit (master) and the
// datapath / register file it steers (slave).
interface mc_control_if;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        PCWr;
    logic        IRWr;
    logic        RFWr;
    logic        MemWr;
    logic [1:0]  RegDst;
    logic [1:0]  MemToReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOp;
    logic [1:0]  PCSrc;
    logic        ExtOp;
    logic [3:0]  State;
    logic [31:0] ICount;

    modport master (
        input  Op, Funct, Zero,
        output PCWr, IRWr, RFWr, MemWr, RegDst, MemToReg, ALUSrcA, ALUSrcB,
               ALUOp, PCSrc, ExtOp, State, ICount
    );

    modport slave (
        output Op, Funct, Zero,
        input  PCWr, IRWr, RFWr, MemWr, RegDst, MemToReg, ALUSrcA, ALUSrcB,
               ALUOp, PCSrc, ExtOp, State, ICount
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control unit: instruction-step FSM, datapath mux
// selects, write enables and a retired-instruction counter.
module mc_control (
    input  logic         CLK,
    input  logic         RST,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EX  = 4'd2,
        S_AWB = 4'd3,
        S_MA  = 4'd4,
        S_MR  = 4'd5,
        S_LWB = 4'd6,
        S_SW  = 4'd7,
        S_BR  = 4'd8,
        S_J   = 4'd9
    } state_t;

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       rfwr;
        logic       memwr;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       extop;
        logic       br;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    function automatic logic legal_funct(input logic [5:0] funct);
        logic ok;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] funct_aluop(input logic [5:0] funct);
        logic [2:0] a;
        case (funct)
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                          input logic [5:0] funct);
        state_t n;
        n = S_IF;
        case (s)
            S_IF: n = S_ID;
            S_ID: begin
                case (op)
                    OP_R:            n = legal_funct(funct) ? S_EX : S_IF;
                    OP_ADDI, OP_ORI: n = S_EX;
                    OP_LW, OP_SW:    n = S_MA;
                    OP_BEQ:          n = S_BR;
                    OP_J, OP_JAL:    n = S_J;
                    default:         n = S_IF;
                endcase
            end
            S_EX:    n = S_AWB;
            S_MA:    n = (op == OP_LW) ? S_MR : S_SW;
            S_MR:    n = S_LWB;
            default: n = S_IF;
        endcase
        return n;
    endfunction

    // Moore decode; br marks the cycle where PCWr follows the live Zero flag.
    function automatic ctrl_t decode(input state_t s, input logic [5:0] op,
                                     input logic [5:0] funct);
        ctrl_t c;
        c = ctrl_t'(18'd0);
        case (s)
            S_IF: begin
                c.irwr    = 1'b1;
                c.pcwr    = 1'b1;
                c.alusrcb = 2'd1;
            end
            S_ID: begin
                c.alusrcb = 2'd3;
                c.extop   = 1'b1;
            end
            S_EX: begin
                if (op == OP_R) begin
                    c.alusrca = 1'b1;
                    c.aluop   = funct_aluop(funct);
                end else if (op == OP_ADDI) begin
                    c.alusrcb = 2'd2;
                    c.extop   = 1'b1;
                end else begin
                    c.alusrcb = 2'd2;
                    c.aluop   = ALU_OR;
                end
            end
            S_AWB: begin
                c.rfwr   = 1'b1;
                c.regdst = (op == OP_R) ? 2'd1 : 2'd0;
            end
            S_MA: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'd2;
                c.extop   = 1'b1;
            end
            S_LWB: begin
                c.rfwr     = 1'b1;
                c.memtoreg = 2'd1;
            end
            S_SW: c.memwr = 1'b1;
            S_BR: begin
                c.alusrca = 1'b1;
                c.aluop   = ALU_SUB;
                c.pcsrc   = 2'd1;
                c.br      = 1'b1;
            end
            S_J: begin
                c.pcwr  = 1'b1;
                c.pcsrc = 2'd2;
                if (op == OP_JAL) begin
                    c.rfwr     = 1'b1;
                    c.regdst   = 2'd2;
                    c.memtoreg = 2'd2;
                end else begin
                    c.rfwr = 1'b0;
                end
            end
            default: c = ctrl_t'(18'd0);
        endcase
        return c;
    endfunction

    state_t      state_r;
    ctrl_t       ctrl_r;
    logic [31:0] icount_r;
    state_t      nxt_s;
    logic        retire_s;
    logic        valid_s;
    logic        wr_ok_s;

    assign nxt_s    = next_state(state_r, bus.Op, bus.Funct);
    assign retire_s = (state_r == S_AWB) || (state_r == S_LWB) || (state_r == S_SW) ||
                      (state_r == S_BR)  || (state_r == S_J);

    // Step the FSM and register the controls of the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= S_IF;
            ctrl_r   <= decode(S_IF, bus.Op, bus.Funct);
            icount_r <= 32'd0;
        end else begin
            state_r <= nxt_s;
            ctrl_r  <= decode(nxt_s, bus.Op, bus.Funct);
            if (retire_s) begin
                icount_r <= icount_r + 32'd1;
            end else begin
                icount_r <= icount_r;
            end
        end
    end

    // An upset into an unused encoding silences every output until IF.
    assign valid_s = (4'(state_r) <= 4'd9);
    assign wr_ok_s = valid_s & ~RST;

    assign bus.PCWr     = (ctrl_r.pcwr | (ctrl_r.br & bus.Zero)) & wr_ok_s;
    assign bus.IRWr     = ctrl_r.irwr  & wr_ok_s;
    assign bus.RFWr     = ctrl_r.rfwr  & wr_ok_s;
    assign bus.MemWr    = ctrl_r.memwr & wr_ok_s;
    assign bus.RegDst   = valid_s ? ctrl_r.regdst   : 2'd0;
    assign bus.MemToReg = valid_s ? ctrl_r.memtoreg : 2'd0;
    assign bus.ALUSrcA  = ctrl_r.alusrca & valid_s;
    assign bus.ALUSrcB  = valid_s ? ctrl_r.alusrcb  : 2'd0;
    assign bus.ALUOp    = valid_s ? ctrl_r.aluop    : 3'd0;
    assign bus.PCSrc    = valid_s ? ctrl_r.pcsrc    : 2'd0;
    assign bus.ExtOp    = ctrl_r.extop & valid_s;
    assign bus.State    = state_r;
    assign bus.ICount   = icount_r;
endmodule
